// File: rtl/snake_move_sched.sv
// snake_move_sched
// Sequences snake movement for the grid datapath: a game-state FSM, a
// periodic move tick and a 2-entry buffer of queued direction changes.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   start             pulse: begin a new game (honoured in IDLE/OVER only)
//   dir_valid/dir_req direction request strobe; 00 up, 01 left, 11 down, 10 right
//   pause_toggle      pulse: RUN <-> PAUSE
//   collision         datapath reports head collision (honoured in RUN only)
//   step/step_dir     one-cycle move strobe and its direction
//   cur_dir           last committed direction
//   state             00 IDLE, 01 RUN, 10 PAUSE, 11 OVER (debug/status view of the FSM)
//   move_count        steps since start, wraps
//
// Handshake: dir_valid is a one-cycle strobe with no ready/backpressure.
// A request is either queued or silently dropped on the edge it is
// sampled; the sender never waits.
module snake_move_sched #(
  parameter int TICK_DIV = 25000000,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir_valid,
  input  logic [1:0]       dir_req,
  input  logic             pause_toggle,
  input  logic             collision,
  output logic             step,
  output logic [1:0]       step_dir,
  output logic [1:0]       cur_dir,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] move_count
);

  localparam int            TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  state_t        st;
  logic [TW-1:0] tick_cnt;
  logic [1:0]    q0;      // queue head (oldest request)
  logic [1:0]    q1;      // second entry, valid when q_cnt == 2
  logic [1:0]    q_cnt;   // occupancy 0..2

  logic       tick;
  logic       pop;
  logic [1:0] dir_ref;
  logic       dir_ok;
  logic       push;

  assign state = st;

  always_comb begin
    tick    = (tick_cnt == TICK_LAST);
    pop     = tick && (q_cnt != 2'd0);
    // Legality is judged against the direction the snake will be facing
    // once everything already queued has been applied.
    dir_ref = (q_cnt == 2'd2) ? q1 : ((q_cnt == 2'd1) ? q0 : cur_dir);
    dir_ok  = dir_valid && (dir_req != dir_ref) && ((dir_req ^ dir_ref) != 2'b11);
    // A full queue still accepts when the head leaves on the same edge.
    push    = dir_ok && ((q_cnt != 2'd2) || pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= S_IDLE;
      cur_dir    <= 2'b00;
      step       <= 1'b0;
      step_dir   <= 2'b00;
      move_count <= '0;
      q0         <= 2'b00;
      q1         <= 2'b00;
      q_cnt      <= 2'd0;
      tick_cnt   <= '0;
    end else begin
      step <= 1'b0;
      case (st)
        S_IDLE, S_OVER: begin
          if (start) begin
            st         <= S_RUN;
            cur_dir    <= 2'b10;
            q_cnt      <= 2'd0;
            tick_cnt   <= '0;
            move_count <= '0;
          end
        end

        S_RUN: begin
          if (collision) begin
            st    <= S_OVER;
            q_cnt <= 2'd0;
          end else if (pause_toggle) begin
            // The pause edge still counts as a RUN cycle, but a tick that
            // would fire here is deferred: the counter parks on its last
            // value so the step fires on the first cycle after resume.
            st <= S_PAUSE;
            if (!tick) tick_cnt <= tick_cnt + TW'(1);
          end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);

            if (tick) begin
              step       <= 1'b1;
              move_count <= move_count + CNT_W'(1);
              step_dir   <= pop ? q0 : cur_dir;
              if (pop) cur_dir <= q0;
            end

            if (pop && push) begin
              // Old head leaves; new entry lands behind whatever remains.
              if (q_cnt == 2'd2) begin
                q0 <= q1;
                q1 <= dir_req;
              end else begin
                q0 <= dir_req;
              end
            end else if (pop) begin
              q0    <= q1;
              q_cnt <= q_cnt - 2'd1;
            end else if (push) begin
              if (q_cnt == 2'd0) q0 <= dir_req;
              else               q1 <= dir_req;
              q_cnt <= q_cnt + 2'd1;
            end
          end
        end

        S_PAUSE: begin
          if (pause_toggle) st <= S_RUN;
        end

        default: st <= S_IDLE;
      endcase
    end
  end

endmodule
